// File: rtl/ddr_frame_burst_writer.sv
// Packs a video word stream into fixed-length DDR write bursts tagged with burst address and flags,
// rotating over NUM_BUF frame buffers and zero-padding frames that are cut short.
module ddr_frame_burst_writer #(
  parameter int DATA_W           = 64,
  parameter int ADDR_W           = 29,
  parameter int BURST_LEN        = 32,
  parameter int BURSTS_PER_FRAME = 3600,
  parameter int NUM_BUF          = 3,
  parameter int BI_W             = 3
) (
  input  logic                        clk_100,
  input  logic                        reset_n,
  input  logic                        start_frame,
  input  logic                        valid_data_ddr,
  input  logic [DATA_W-1:0]           data_ddr,
  input  logic [NUM_BUF*32-1:0]       reg_addr_buf,
  input  logic                        rd_lock_en,
  input  logic [BI_W-1:0]             rd_buf,
  output logic                        fifo_wr,
  output logic [DATA_W+ADDR_W+2:0]    data_fifo_frame,
  output logic                        end_frame,
  output logic                        last_burst,
  output logic [BI_W-1:0]             cur_buf,
  output logic [BI_W-1:0]             done_buf,
  output logic                        frame_err,
  output logic [15:0]                 drop_cnt
);

  localparam int WC_W = $clog2(BURST_LEN);
  localparam int BC_W = $clog2(BURSTS_PER_FRAME + 1);
  localparam int FW   = DATA_W + ADDR_W + 3;

  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, PAD = 2'd2, DONE = 2'd3} state_t;

  state_t              state_r;
  logic [WC_W-1:0]     word_cnt_r;
  logic [BC_W-1:0]     burst_cnt_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [BI_W-1:0]     cur_buf_r;
  logic [BI_W-1:0]     done_buf_r;
  logic [15:0]         drop_cnt_r;
  logic                fifo_wr_r;
  logic [FW-1:0]       data_fifo_frame_r;
  logic                end_frame_r;
  logic                frame_err_r;

  logic                last_word_s;
  logic                final_burst_s;
  logic                frame_end_s;
  logic                do_start_s;
  logic [BI_W-1:0]     nb_s;
  logic [ADDR_W-1:0]   base_s;
  logic                unused_s;

  // Round-robin successor, optionally stepping over the buffer the reader holds
  function automatic logic [BI_W-1:0] next_buf(input logic [BI_W-1:0] cur,
                                                input logic            lock,
                                                input logic [BI_W-1:0] rd);
    logic [BI_W-1:0] nb;
    nb = (cur >= BI_W'(NUM_BUF - 1)) ? {BI_W{1'b0}} : cur + BI_W'(1);
    if (lock && (NUM_BUF >= 3) && (nb == rd)) begin
      nb = (nb >= BI_W'(NUM_BUF - 1)) ? {BI_W{1'b0}} : nb + BI_W'(1);
    end
    return nb;
  endfunction

  assign last_word_s   = (word_cnt_r == WC_W'(BURST_LEN - 1));
  assign final_burst_s = (burst_cnt_r == BC_W'(BURSTS_PER_FRAME - 1));
  assign frame_end_s   = last_word_s & final_burst_s;
  assign nb_s          = next_buf(cur_buf_r, rd_lock_en, rd_buf);
  assign base_s        = reg_addr_buf[32*nb_s +: ADDR_W];
  assign unused_s      = ^reg_addr_buf;

  // Decide whether a new frame is launched this cycle
  always_comb begin
    do_start_s = 1'b0;
    case (state_r)
      IDLE, DONE: do_start_s = start_frame;
      ACTIVE:     do_start_s = start_frame &&
                               ((valid_data_ddr && frame_end_s) || (word_cnt_r == {WC_W{1'b0}}));
      PAD:        do_start_s = last_word_s;
      default:    do_start_s = 1'b0;
    endcase
  end

  // Frame FSM, counters and registered write-FIFO outputs
  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) begin
      state_r           <= IDLE;
      word_cnt_r        <= {WC_W{1'b0}};
      burst_cnt_r       <= {BC_W{1'b0}};
      addr_r            <= {ADDR_W{1'b0}};
      cur_buf_r         <= {BI_W{1'b0}};
      done_buf_r        <= {BI_W{1'b0}};
      drop_cnt_r        <= 16'd0;
      fifo_wr_r         <= 1'b0;
      data_fifo_frame_r <= {FW{1'b0}};
      end_frame_r       <= 1'b0;
      frame_err_r       <= 1'b0;
    end else begin
      fifo_wr_r   <= 1'b0;
      end_frame_r <= 1'b0;
      frame_err_r <= 1'b0;
      case (state_r)
        IDLE, DONE: begin
          state_r <= state_r;
        end
        ACTIVE: begin
          if (start_frame && !(valid_data_ddr && frame_end_s)) begin
            // Abort: the word presented with the start is not taken
            frame_err_r <= 1'b1;
            state_r     <= PAD;
          end else if (valid_data_ddr) begin
            fifo_wr_r         <= 1'b1;
            data_fifo_frame_r <= {last_word_s, frame_end_s, 1'b0, addr_r, data_ddr};
            word_cnt_r        <= word_cnt_r + WC_W'(1);
            if (last_word_s) begin
              addr_r      <= addr_r + ADDR_W'(BURST_LEN);
              burst_cnt_r <= burst_cnt_r + BC_W'(1);
            end else begin
              addr_r      <= addr_r;
            end
            if (frame_end_s) begin
              end_frame_r <= 1'b1;
              done_buf_r  <= cur_buf_r;
              state_r     <= DONE;
            end else begin
              state_r     <= ACTIVE;
            end
          end else begin
            state_r <= ACTIVE;
          end
        end
        PAD: begin
          fifo_wr_r         <= 1'b1;
          data_fifo_frame_r <= {last_word_s, 1'b0, 1'b1, addr_r, {DATA_W{1'b0}}};
          word_cnt_r        <= word_cnt_r + WC_W'(1);
          if (valid_data_ddr && (drop_cnt_r != 16'hFFFF)) begin
            drop_cnt_r <= drop_cnt_r + 16'd1;
          end else begin
            drop_cnt_r <= drop_cnt_r;
          end
          frame_err_r <= start_frame;
        end
        default: state_r <= IDLE;
      endcase
      if (do_start_s) begin
        cur_buf_r   <= nb_s;
        addr_r      <= base_s;
        word_cnt_r  <= {WC_W{1'b0}};
        burst_cnt_r <= {BC_W{1'b0}};
        state_r     <= ACTIVE;
      end
    end
  end

  assign fifo_wr         = fifo_wr_r;
  assign data_fifo_frame = data_fifo_frame_r;
  assign end_frame       = end_frame_r;
  assign last_burst      = ((state_r == ACTIVE) || (state_r == PAD)) && final_burst_s;
  assign cur_buf         = cur_buf_r;
  assign done_buf        = done_buf_r;
  assign frame_err       = frame_err_r;
  assign drop_cnt        = drop_cnt_r;

endmodule

// File: tb/tb_ddr_frame_burst_writer.sv
// Randomized bench for ddr_frame_burst_writer: every cycle is compared against a
// frame/word-count reference model, after directed runs of the main scenarios.
module tb_ddr_frame_burst_writer;
  localparam int DW  = 64;
  localparam int AW  = 29;
  localparam int BL  = 4;
  localparam int BPF = 3;
  localparam int NB  = 3;
  localparam int BW  = 3;
  localparam int FW  = DW + AW + 3;
  localparam int FRAME_WORDS = BL * BPF;

  logic clk_100 = 1'b0;
  logic reset_n = 1'b0;
  logic start_frame = 1'b0;
  logic valid_data_ddr = 1'b0;
  logic [DW-1:0] data_ddr = '0;
  logic [NB*32-1:0] reg_addr_buf = {32'h3000, 32'h2000, 32'h1000};
  logic rd_lock_en = 1'b0;
  logic [BW-1:0] rd_buf = '0;
  logic fifo_wr, end_frame, last_burst, frame_err;
  logic [FW-1:0] data_fifo_frame;
  logic [BW-1:0] cur_buf, done_buf;
  logic [15:0] drop_cnt;

  ddr_frame_burst_writer #(.DATA_W(DW), .ADDR_W(AW), .BURST_LEN(BL), .BURSTS_PER_FRAME(BPF),
                           .NUM_BUF(NB), .BI_W(BW)) dut (
    .clk_100(clk_100), .reset_n(reset_n), .start_frame(start_frame),
    .valid_data_ddr(valid_data_ddr), .data_ddr(data_ddr), .reg_addr_buf(reg_addr_buf),
    .rd_lock_en(rd_lock_en), .rd_buf(rd_buf), .fifo_wr(fifo_wr),
    .data_fifo_frame(data_fifo_frame), .end_frame(end_frame), .last_burst(last_burst),
    .cur_buf(cur_buf), .done_buf(done_buf), .frame_err(frame_err), .drop_cnt(drop_cnt));

  always #5 clk_100 = ~clk_100;

  int n_checks = 0;
  int n_errs = 0;
  int base_tab [NB] = '{32'h1000, 32'h2000, 32'h3000};

  // model: 0 idle, 1 in frame, 2 padding, 3 frame done
  int mode, n, cur, dbuf, drop, pads_left, base;
  logic e_wr, e_end, e_err, e_lb;
  logic [FW-1:0] e_data;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mode = 0; n = 0; cur = 0; dbuf = 0; drop = 0; pads_left = 0; base = 0;
    e_wr = 1'b0; e_end = 1'b0; e_err = 1'b0; e_lb = 1'b0; e_data = '0;
  endtask

  task automatic model(input logic sf, input logic v, input logic [DW-1:0] d);
    bit start;
    logic [AW-1:0] a;
    int nb;
    start = 0;
    e_wr = 1'b0; e_end = 1'b0; e_err = 1'b0;
    a = AW'(base + (n / BL) * BL);
    if (mode == 0 || mode == 3) begin
      start = sf;
    end else if (mode == 1) begin
      if (sf && !(v && n == FRAME_WORDS - 1)) begin
        e_err = 1'b1;
        if (n % BL == 0) start = 1;
        else begin mode = 2; pads_left = BL - n % BL; end
      end else if (v) begin
        e_wr = 1'b1;
        e_data = {(n % BL == BL - 1), (n == FRAME_WORDS - 1), 1'b0, a, d};
        n++;
        if (n == FRAME_WORDS) begin
          e_end = 1'b1; dbuf = cur; mode = 3;
          if (sf) start = 1;
        end
      end
    end else begin
      e_wr = 1'b1;
      e_data = {(pads_left == 1), 1'b0, 1'b1, a, {DW{1'b0}}};
      pads_left--;
      if (v && drop < 65535) drop++;
      if (sf) e_err = 1'b1;
      if (pads_left == 0) start = 1;
    end
    if (start) begin
      nb = (cur + 1) % NB;
      if (rd_lock_en && NB >= 3 && nb == int'(rd_buf)) nb = (nb + 1) % NB;
      cur = nb; base = base_tab[nb]; n = 0; mode = 1;
    end
    e_lb = (mode == 1 || mode == 2) && (n / BL == BPF - 1);
  endtask

  task automatic step(input logic sf, input logic v);
    logic [DW-1:0] d;
    d = {$urandom, $urandom};
    start_frame = sf; valid_data_ddr = v; data_ddr = d;
    model(sf, v, d);
    @(posedge clk_100); #1;
    check("fifo_wr", fifo_wr, e_wr);
    if (e_wr) check("entry", data_fifo_frame, e_data);
    check("end_frame", end_frame, e_end);
    check("frame_err", frame_err, e_err);
    check("last_burst", last_burst, e_lb);
    check("cur_buf", cur_buf, cur);
    check("done_buf", done_buf, dbuf);
    check("drop_cnt", drop_cnt, drop);
    start_frame = 1'b0; valid_data_ddr = 1'b0;
  endtask

  task automatic do_reset();
    start_frame = 1'b0; valid_data_ddr = 1'b0;
    reset_n = 1'b0;
    #3;
    check("rst_fifo_wr", fifo_wr, 0);
    check("rst_entry", data_fifo_frame, 0);
    check("rst_end_frame", end_frame, 0);
    check("rst_last_burst", last_burst, 0);
    check("rst_cur_buf", cur_buf, 0);
    check("rst_done_buf", done_buf, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    model_reset();
    @(posedge clk_100); #1;
    reset_n = 1'b1;
  endtask

  task automatic full_frame(input int exp_buf);
    step(1'b1, 1'b0);
    check("frame_buf", cur_buf, exp_buf);
    for (int i = 0; i < FRAME_WORDS; i++) step(1'b0, 1'b1);
  endtask

  initial begin
    model_reset();
    do_reset();

    // frame rotation 1,2,0,1 and idle words after completion
    full_frame(1);
    check("done_after_first", done_buf, 1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    full_frame(2);
    full_frame(0);
    full_frame(1);

    // reader lock on buffer 2: 1,0,1,0
    rd_lock_en = 1'b1; rd_buf = 3'd2;
    do_reset();
    full_frame(1);
    full_frame(0);
    full_frame(1);
    full_frame(0);
    rd_lock_en = 1'b0;

    // abort after 6 words with valid held high: two pads, two drops
    do_reset();
    step(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("abort_drops", drop_cnt, 2);
    check("abort_done_buf", done_buf, 0);
    check("abort_new_buf", cur_buf, 2);

    // abort on a burst boundary restarts at once
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    check("boundary_restart_buf", cur_buf, 0);
    for (int i = 0; i < 11; i++) step(1'b0, 1'b1);

    // start coincident with the last word
    step(1'b1, 1'b1);
    check("coincident_end", end_frame, 1);
    check("coincident_buf", cur_buf, 1);
    step(1'b0, 1'b1);

    // reset mid-frame
    step(1'b0, 1'b1);
    do_reset();

    for (int c = 0; c < 4000; c++) begin
      rd_lock_en = ($urandom_range(0, 3) == 0);
      rd_buf = BW'($urandom_range(0, NB - 1));
      if ($urandom_range(0, 999) == 0) do_reset();
      else step($urandom_range(0, 24) == 0, $urandom_range(0, 9) < 7);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
